fetch_unit: RTL and testbench

Instruction-fetch stage front end. Owns the architectural fetch PC, issues single-outstanding requests on the instruction bus, buffers the returned word and presents it as `dataF_nxt` to the IF/ID pipeline register. It honours the downstream fetch stall and accepts PC redirects from execute/commit, which flush any in-flight or buffered instruction.

---
 rtl/fetch_unit_pkg.sv | 39 +++
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch front end.
//   common : instruction-bus request/response structs, default reset PC and
//            the fetch FSM state enum.
//   pipes  : fetch_data_t, the record handed to the IF/ID pipeline register.
package common;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  // REQ: request outstanding, BUF: word held for IF/ID,
  // DRAIN: waiting out a response that a redirect made stale.
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_BUF   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

package pipes;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        misaligned;
  } fetch_data_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-bus bundle between fetch_unit (master) and memory (slave).
//   ireq  : request  {valid, addr[63:0]}, driven by the master
//   iresp : response {addr_ok, data_ok, data[31:0]}, driven by the slave
interface fetch_unit_if;
  import common::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;

  modport master (output ireq, input iresp);
  modport slave  (input ireq, output iresp);

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage front end. Owns the fetch PC, keeps a single
// request outstanding on the instruction bus, buffers the returned word and
// presents it to IF/ID. Redirects flush any in-flight or buffered word.
//
// Ports:
//   clk, reset      core clock; synchronous active-high reset
//   ibus            instruction bus (master modport of fetch_unit_if)
//   stallF          downstream stall; the buffered word is held
//   redirect_valid  single-cycle redirect/flush request
//   redirect_pc     redirect target
//   dataF_nxt       {valid, pc, raw_instr, misaligned} toward IF/ID
//
// Build option: define FETCH_MISALIGN_CHECK_EN to turn a PC with pc[1:0]!=0
// into a misaligned entry without touching the bus. Undefined, misaligned
// is tied 0 and the address is issued unchanged.
module fetch_unit
  import common::*;
  import pipes::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master ibus,
  input  logic         stallF,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  output fetch_data_t  dataF_nxt
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [63:0]  tgt_pc_q, tgt_pc_d;

  logic         data_ok;
  logic         pc_misaligned;
  logic         unused_addr_ok;

  assign data_ok        = ibus.iresp.data_ok;
  // Transfers complete on data_ok alone; the address handshake carries no state.
  assign unused_addr_ok = ibus.iresp.addr_ok;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  // Next-state logic. Redirect outranks data_ok and stallF in every state.
  always_comb begin
    // NOTE: every variable gets a default up front so no path infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    tgt_pc_d    = tgt_pc_q;

    case (state_q)
      ST_REQ: begin
        if (pc_misaligned) begin
          // No bus traffic: behaves like a 0-wait fetch of an all-zero word.
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else begin
            buf_instr_d = '0;
            state_d     = ST_BUF;
          end
        end else if (redirect_valid) begin
          if (data_ok) begin
            pc_d = redirect_pc;            // response arrives now: drop it
          end else begin
            tgt_pc_d = redirect_pc;        // response still owed: wait it out
            state_d  = ST_DRAIN;
          end
        end else if (data_ok) begin
          buf_instr_d = ibus.iresp.data;
          state_d     = ST_BUF;
        end
      end

      ST_BUF: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if (!stallF) begin
          pc_d    = pc_q + 64'd4;          // wraps naturally at 2^64
          state_d = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (redirect_valid) begin
          if (data_ok) begin
            pc_d    = redirect_pc;
            state_d = ST_REQ;
          end else begin
            tgt_pc_d = redirect_pc;        // latest redirect wins
          end
        end else if (data_ok) begin
          pc_d    = tgt_pc_q;
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_REQ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_REQ;
      pc_q        <= PC_RESET;
      buf_instr_q <= '0;
      tgt_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      tgt_pc_q    <= tgt_pc_d;
    end
  end

  // Output decode. The request address is pc_q in both REQ and DRAIN, so it
  // stays stable until data_ok; reset masks both outputs immediately.
  always_comb begin
    ibus.ireq       = '0;
    ibus.ireq.addr  = pc_q;
    dataF_nxt       = '0;
    if (!reset) begin
      case (state_q)
        ST_REQ:   ibus.ireq.valid = !pc_misaligned;
        ST_DRAIN: ibus.ireq.valid = 1'b1;
        ST_BUF: begin
          dataF_nxt.valid      = 1'b1;
          dataF_nxt.pc         = pc_q;
          dataF_nxt.raw_instr  = buf_instr_q;
          dataF_nxt.misaligned = pc_misaligned;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A bus model answers requests after a
// programmable or random number of wait cycles; a transaction-level model
// tracks the PC the next delivered instruction must carry and pushes the
// expected entry whenever a live response (or a misaligned pseudo-fetch)
// completes. A monitor compares dataF_nxt every cycle against the queue head
// and pops entries as IF/ID consumes them.
module tb_fetch_unit;
  import common::*;
  import pipes::*;

  localparam logic [63:0] PC_RESET = 64'h8000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stallF;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  fetch_data_t dataF_nxt;

  fetch_unit_if ibus ();

  fetch_unit #(.PC_RESET(PC_RESET)) dut (
    .clk            (clk),
    .reset          (reset),
    .ibus           (ibus.master),
    .stallF         (stallF),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dataF_nxt      (dataF_nxt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state.
  exp_t        exp_q[$];
  logic [63:0] model_pc;     // PC of the next instruction to be delivered
  bit          busy;         // a bus transfer is outstanding
  bit          stale;        // the outstanding transfer predates a redirect
  logic [63:0] busy_addr;
  int          wait_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive controls at negedge, answer the bus, update the model.
  // wait_n < 0 picks a random 0..3 wait for a newly started transfer.
  task automatic cycle(input logic rst, input logic stall, input logic redir,
                       input logic [63:0] rpc, input int wait_n);
    logic mis_req;
    logic fetched;
    exp_t e;
    @(negedge clk);
    reset          = rst;
    stallF         = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    ibus.iresp     = '0;
    #1;
    if (rst) begin
      exp_q.delete();
      model_pc = PC_RESET;
      busy     = 1'b0;
      stale    = 1'b0;
      return;
    end
    fetched = 1'b0;
    // Queue empty with nothing owed means the fetcher sits at model_pc.
    mis_req = MIS_EN && !busy && !stale && exp_q.size() == 0 && model_pc[1:0] != 2'b00;

    if (!busy && ibus.ireq.valid) begin
      busy      = 1'b1;
      busy_addr = ibus.ireq.addr;
      wait_cnt  = (wait_n < 0) ? int'($urandom_range(0, 3)) : wait_n;
      check("req_addr", ibus.ireq.addr, model_pc);
    end else if (busy) begin
      check("req_hold", {ibus.ireq.valid, ibus.ireq.addr}, {1'b1, busy_addr});
    end
    if (busy) begin
      if (wait_cnt == 0) begin
        ibus.iresp.data_ok = 1'b1;
        ibus.iresp.data    = mem_word(busy_addr);
        busy               = 1'b0;
        fetched            = 1'b1;
      end else begin
        wait_cnt--;
      end
    end
    ibus.iresp.addr_ok = 1'($urandom_range(0, 1));

    if (redir) begin
      exp_q.delete();
      model_pc = rpc;
      stale    = busy;            // a response still owed must be discarded
    end else if (fetched) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        e = '{pc: model_pc, instr: mem_word(model_pc), mis: 1'b0};
        exp_q.push_back(e);
        model_pc = model_pc + 64'd4;
      end
    end else if (mis_req) begin
      e = '{pc: model_pc, instr: 32'h0, mis: 1'b1};
      exp_q.push_back(e);
      model_pc = model_pc + 64'd4;
    end
  endtask

  // Monitor: just after each edge, retire a consumed entry and compare.
  initial begin : monitor
    int          shown;
    exp_t        e;
    fetch_data_t exp_d;
    logic        exp_req_v;
    shown = 0;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (reset) shown = 0;
      else if (shown != 0 && !stallF && !redirect_valid && exp_q.size() != 0)
        void'(exp_q.pop_front());
      exp_d = '0;
      if (exp_q.size() != 0) begin
        e     = exp_q[0];
        exp_d = '{valid: 1'b1, pc: e.pc, raw_instr: e.instr, misaligned: e.mis};
      end
      check("dataF_nxt", dataF_nxt, exp_d);
      shown     = exp_q.size();
      exp_req_v = !reset && exp_q.size() == 0 &&
                  !(MIS_EN && !stale && model_pc[1:0] != 2'b00);
      check("ireq_valid", ibus.ireq.valid, exp_req_v);
    end
  end

  initial begin : stim
    logic [63:0] rpc;
    reset          = 1'b1;
    stallF         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ibus.iresp     = '0;
    model_pc       = PC_RESET;
    busy           = 1'b0;
    stale          = 1'b0;

    repeat (3) cycle(1, 0, 0, '0, 0);
    // 0-wait streaming, then a 3-cycle stall while buffered.
    repeat (5) cycle(0, 0, 0, '0, 0);
    repeat (3) cycle(0, 1, 0, '0, 0);
    cycle(0, 0, 0, '0, 0);
    // 3-wait request, redirect in its first wait cycle.
    cycle(0, 0, 0, '0, 3);
    cycle(0, 0, 1, 64'h8000_1000, -1);
    repeat (2) cycle(0, 0, 0, '0, -1);
    cycle(0, 0, 0, '0, 0);
    // Redirect while buffered and stalled.
    cycle(0, 1, 1, 64'h8000_2000, 0);
    // Two redirects during DRAIN; fetch must resume at 0x200.
    cycle(0, 0, 0, '0, 3);
    cycle(0, 0, 1, 64'h100, -1);
    cycle(0, 0, 1, 64'h200, -1);
    cycle(0, 0, 0, '0, -1);
    repeat (2) cycle(0, 0, 0, '0, 0);
    // Redirect coinciding with data_ok, then wrap from the top of memory.
    cycle(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    repeat (3) cycle(0, 0, 0, '0, 0);
    cycle(0, 1, 0, '0, 0);
    cycle(0, 1, 1, 64'h8000_0002, 0);
    repeat (2) cycle(0, 0, 0, '0, 0);
    cycle(0, 0, 1, 64'h8000_0000, 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        repeat ($urandom_range(1, 2)) cycle(1, 0, 0, '0, 0);
      end else begin
        rpc = {$urandom(), $urandom()} & ~64'h3;
        case ($urandom_range(0, 5))
          0: rpc = 64'hFFFF_FFFF_FFFF_FFFC;
          1: rpc = rpc | 64'h2;
          default: ;
        endcase
        cycle(0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), rpc, -1);
      end
    end
    repeat (4) cycle(0, 0, 0, '0, -1);

    done = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
